// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: imem request/response channels, redirect input and decode output.
// With FETCH_MISALIGN_CHECK_EN defined the bundle also carries misalign_err.
interface instr_fetch_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        misalign_err;

    modport master (
        output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc, misalign_err,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
               instr_ready
    );
    modport slave (
        input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc, misalign_err,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
               instr_ready
    );
`else
    modport master (
        output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
               instr_ready
    );
    modport slave (
        input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
               instr_ready
    );
`endif
endinterface

// File: rtl/instr_fetch.sv
// Fetch stage: credit-limited imem requests, in-order response FIFO towards decode, redirect flush.
// Optional FETCH_MISALIGN_CHECK_EN: misaligned redirect sets sticky misalign_err and halts fetch.
module instr_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_fetch_if.master bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0]   DEPTH_W = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] FULL    = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    typedef enum logic {FETCH, DRAIN} state_t;

    state_t           state;
    logic [31:0]      fetch_pc;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] fifo_count;
    logic [PTR_W-1:0] tag_wr, tag_rd, fifo_wr, fifo_rd;
    logic [31:0]      tag_q      [FIFO_DEPTH];
    logic [31:0]      fifo_instr [FIFO_DEPTH];
    logic [31:0]      fifo_pc    [FIFO_DEPTH];

    logic             req_fire, pop, drop, push;
    logic [CNT_W-1:0] outstanding_nx, drop_nx;
    logic [CNT_W:0]   credit_used;
    logic [31:0]      redirect_target;
    logic             halt, halt_nx;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misalign;

    assign misalign        = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
    assign redirect_target = bus.redirect_pc;
    assign halt_nx         = halt || misalign;
    assign bus.misalign_err = halt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) halt <= 1'b0;
        else        halt <= halt_nx;
    end
`else
    assign redirect_target = bus.redirect_pc & 32'hFFFF_FFFC;
    assign halt            = 1'b0;
    assign halt_nx         = 1'b0;
`endif

    // A head popped this cycle frees its slot before any response to a new request can land,
    // which keeps one request per cycle flowing with single-cycle memory.
    assign pop         = bus.instr_valid && bus.instr_ready;
    assign credit_used = {1'b0, outstanding} + {1'b0, fifo_count} - (CNT_W + 1)'(pop);

    assign bus.imem_req_valid = rst_n && (state == FETCH) && !bus.redirect_valid &&
                                (credit_used < DEPTH_W);
    assign bus.imem_req_addr  = fetch_pc;
    assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

    assign bus.instr_valid = (fifo_count != '0);
    assign bus.instr       = fifo_instr[fifo_rd];
    assign bus.instr_pc    = fifo_pc[fifo_rd];

    assign drop = bus.imem_rsp_valid && ((drop_cnt != '0) || bus.redirect_valid);
    assign push = bus.imem_rsp_valid && !drop;

    assign outstanding_nx = outstanding + CNT_W'(req_fire) - CNT_W'(bus.imem_rsp_valid);
    // On redirect everything still in flight after this cycle is stale.
    assign drop_nx = bus.redirect_valid ? outstanding_nx
                   : drop_cnt - CNT_W'(bus.imem_rsp_valid && (drop_cnt != '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FETCH;
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            tag_wr      <= '0;
            tag_rd      <= '0;
            fifo_wr     <= '0;
            fifo_rd     <= '0;
            fifo_count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                tag_q[i]      <= '0;
                fifo_instr[i] <= '0;
                fifo_pc[i]    <= '0;
            end
        end else begin
            outstanding <= outstanding_nx;
            drop_cnt    <= drop_nx;
            state       <= ((drop_nx != '0) || halt_nx) ? DRAIN : FETCH;

            if (req_fire) begin
                tag_q[tag_wr] <= fetch_pc;
                tag_wr        <= tag_wr + PTR_ONE;
                fetch_pc      <= fetch_pc + 32'd4;
            end
            if (bus.imem_rsp_valid) tag_rd <= tag_rd + PTR_ONE;

            if (bus.redirect_valid) begin
                fetch_pc   <= redirect_target;
                fifo_wr    <= '0;
                fifo_rd    <= '0;
                fifo_count <= '0;
            end else begin
                if (push) begin
                    fifo_instr[fifo_wr] <= bus.imem_rsp_data;
                    fifo_pc[fifo_wr]    <= tag_q[tag_rd];
                    fifo_wr             <= fifo_wr + PTR_ONE;
                end
                if (pop) fifo_rd <= fifo_rd + PTR_ONE;
                fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    overflow_chk: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && !bus.redirect_valid && (fifo_count == FULL)));

endmodule
